// File: rtl/mem_rsp_pkg.sv
// Shared types and defaults for the mem_rsp_ctrl single-port memory responder.
// Compile with MEM_RSP_WAIT_EN defined to enable programmable wait states.
package mem_rsp_pkg;

  localparam int DEF_DEPTH_WORDS = 1024;
  localparam int DEF_WAIT_W      = 4;

  localparam logic PORT_DATA = 1'b0;
  localparam logic PORT_FET  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // word_addr is the byte address with its two low bits dropped
  function automatic logic addr_out_of_range(input logic [29:0] word_addr,
                                             input int depth_words);
    return word_addr >= 30'(depth_words);
  endfunction

endpackage

// File: rtl/mem_rsp_ctrl_if.sv
// Fetch and data request/response bundle between a core and mem_rsp_ctrl.
interface mem_rsp_ctrl_if;

  // A requester raises *_req_i with stable address/controls and keeps it high
  // until the matching *_ready_o pulse; ready is a single-cycle completion
  // strobe, and mem_err_o/data outputs are meaningful only while it is high.
  logic        fet_req_i;
  logic [31:0] fet_addr_i;
  logic        fet_ready_o;
  logic [31:0] fet_data_o;

  logic        mem_req_i;
  logic        mem_we_i;
  logic [3:0]  mem_be_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic        mem_ready_o;
  logic [31:0] mem_rdata_o;
  logic        mem_err_o;

  modport master (
    output fet_req_i, fet_addr_i,
    output mem_req_i, mem_we_i, mem_be_i, mem_addr_i, mem_wdata_i,
    input  fet_ready_o, fet_data_o,
    input  mem_ready_o, mem_rdata_o, mem_err_o
  );

  modport slave (
    input  fet_req_i, fet_addr_i,
    input  mem_req_i, mem_we_i, mem_be_i, mem_addr_i, mem_wdata_i,
    output fet_ready_o, fet_data_o,
    output mem_ready_o, mem_rdata_o, mem_err_o
  );

endinterface

// File: rtl/mem_rsp_array.sv
// Single-port synchronous word RAM: byte-enabled write, registered read.
module mem_rsp_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk_i,
  input  logic [AW-1:0] addr,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_rsp_ctrl.sv
// Arbitrates fetch and data requests onto one RAM port; IDLE/WAIT/RESP FSM.
// MEM_RSP_WAIT_EN adds the wait_cfg_i port and the WAIT state.
module mem_rsp_ctrl
  import mem_rsp_pkg::*;
#(
  parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int WAIT_W      = DEF_WAIT_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
`ifdef MEM_RSP_WAIT_EN
  input  logic [WAIT_W-1:0] wait_cfg_i,
`endif
  mem_rsp_ctrl_if.slave     bus,
  output state_t            state_o
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_t            state_q, state_d;
  logic              port_q, rr_q, we_q, err_q;
  logic [3:0]        be_q;
  logic [31:0]       wdata_q;
  logic [AW-1:0]     idx_q;
  logic [WAIT_W-1:0] wcnt_q;
  logic [31:0]       fet_data_q, mem_rdata_q;

  logic [WAIT_W-1:0] wait_cnt;
`ifdef MEM_RSP_WAIT_EN
  assign wait_cnt = wait_cfg_i;
`else
  assign wait_cnt = '0;
`endif

  logic        tie, grant, accept, g_err;
  logic [31:0] g_addr;

  // rr_q names the port that wins the next tie; only ties move it.
  always_comb begin
    tie   = bus.fet_req_i && bus.mem_req_i;
    grant = PORT_DATA;
    if (tie)                grant = rr_q;
    else if (bus.fet_req_i) grant = PORT_FET;
    g_addr = (grant == PORT_FET) ? bus.fet_addr_i : bus.mem_addr_i;
    g_err  = addr_out_of_range(g_addr[31:2], DEPTH_WORDS) ||
             ((grant == PORT_DATA) && (g_addr[1:0] != 2'b00));
    accept = (state_q == ST_IDLE) && (bus.fet_req_i || bus.mem_req_i);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = (wait_cnt != '0) ? ST_WAIT : ST_RESP;
      ST_WAIT: if (wcnt_q == '0) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  logic        resp, fet_rdy, mem_rdy, ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0] ram_rdata, rsp_word;

  // Reset gates the response and the write so an interrupted access leaves no trace.
  always_comb begin
    resp     = (state_q == ST_RESP) && !rst_i;
    fet_rdy  = resp && (port_q == PORT_FET);
    mem_rdy  = resp && (port_q == PORT_DATA);
    ram_we   = resp && we_q && !err_q;
    ram_addr = (state_q == ST_IDLE) ? g_addr[AW+1:2] : idx_q;
    // stores and rejected accesses return zero data
    rsp_word = (err_q || we_q) ? 32'h0 : ram_rdata;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      wcnt_q      <= '0;
      rr_q        <= PORT_DATA;
      port_q      <= PORT_DATA;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      be_q        <= '0;
      wdata_q     <= '0;
      idx_q       <= '0;
      fet_data_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        port_q  <= grant;
        we_q    <= (grant == PORT_DATA) && bus.mem_we_i;
        be_q    <= bus.mem_be_i;
        wdata_q <= bus.mem_wdata_i;
        idx_q   <= g_addr[AW+1:2];
        err_q   <= g_err;
        wcnt_q  <= (wait_cnt != '0) ? wait_cnt - 1'b1 : '0;
        if (tie) rr_q <= ~grant;
      end else if ((state_q == ST_WAIT) && (wcnt_q != '0)) begin
        wcnt_q <= wcnt_q - 1'b1;
      end
      if (fet_rdy) fet_data_q  <= rsp_word;
      if (mem_rdy) mem_rdata_q <= rsp_word;
    end
  end

  mem_rsp_array #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_array (
    .clk_i (clk_i),
    .addr  (ram_addr),
    .we    (ram_we),
    .be    (be_q),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  assign bus.fet_ready_o = fet_rdy;
  assign bus.mem_ready_o = mem_rdy;
  assign bus.mem_err_o   = mem_rdy && err_q;
  assign bus.fet_data_o  = rst_i ? 32'h0 : (fet_rdy ? rsp_word : fet_data_q);
  assign bus.mem_rdata_o = rst_i ? 32'h0 : (mem_rdy ? rsp_word : mem_rdata_q);
  assign state_o         = state_q;

endmodule
